add_checker: RTL and testbench

ADD_CHECKER -- requirements
Module: add_checker

---
 rtl/add_checker_pkg.sv | 15 +
 rtl/add_ref.sv | 13 +
 rtl/add_checker.sv | 129 ++++++++++++
 tb/tb_add_checker.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/add_checker_pkg.sv
// rtl/add_checker_pkg.sv - shared state type and widths for the adder sweep checker
package add_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] VEC_LAST = 8'hFF;
  localparam int         OPW      = 4;
  localparam int         RESW     = 5;

endpackage

// File: rtl/add_ref.sv
// rtl/add_ref.sv - combinational 4-bit golden adder producing a 5-bit sum
module add_ref
  import add_checker_pkg::*;
(
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  output logic [RESW-1:0] sum
);

  // zero-extend both operands so the carry lands in the top bit
  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/add_checker.sv
// rtl/add_checker.sv - exhaustive 4-bit adder sweep checker; optional first-error capture under ADD_CHECKER_FIRST_ERR_EN
module add_checker
  import add_checker_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [OPW-1:0]  num1,
  output logic [OPW-1:0]  num2,
  input  logic [OPW-1:0]  sum_in,
  input  logic            cout_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [8:0]      err_count,
  output logic [12:0]     first_err
);

  // counter reload leaves SETTLE cycles in DRIVE (counts SETTLE-1 down to 0)
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t          state;
  state_t          state_next;
  logic [7:0]      idx;
  logic [3:0]      settle_cnt;
  logic [RESW-1:0] golden;
  logic            mismatch;

  add_ref u_add_ref (
    .a   (num1),
    .b   (num2),
    .sum (golden)
  );

  assign mismatch = ({cout_in, sum_in} != golden);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state and status outputs decoded from the current state
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    pass       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = DRIVE;
      end
      DRIVE: begin
        busy = 1'b1;
        if (settle_cnt == 4'd0) state_next = CHECK;
      end
      CHECK: begin
        busy       = 1'b1;
        state_next = (idx == VEC_LAST) ? DONE : DRIVE;
      end
      DONE: begin
        done = 1'b1;
        pass = (err_count == 9'd0);
        if (start) state_next = DRIVE;
      end
      default: state_next = IDLE;
    endcase
  end

  // vector index, registered operands, settle counter and error count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 8'd0;
      num1       <= '0;
      num2       <= '0;
      settle_cnt <= 4'd0;
      err_count  <= 9'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx        <= 8'd0;
            num1       <= '0;
            num2       <= '0;
            settle_cnt <= SETTLE_LOAD;
            err_count  <= 9'd0;
          end
        end
        DRIVE: begin
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        CHECK: begin
          if (mismatch) err_count <= err_count + 9'd1;
          if (idx != VEC_LAST) begin
            idx          <= idx + 8'd1;
            {num1, num2} <= idx + 8'd1;
            settle_cnt   <= SETTLE_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADD_CHECKER_FIRST_ERR_EN
  logic [12:0] first_err_q;

  // capture the first failing vector of the sweep; cleared by start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_q <= 13'd0;
    end else if ((state == IDLE || state == DONE) && start) begin
      first_err_q <= 13'd0;
    end else if (state == CHECK && mismatch && err_count == 9'd0) begin
      first_err_q <= {num1, num2, cout_in, sum_in};
    end
  end

  assign first_err = first_err_q;
`else
  assign first_err = 13'd0;
`endif

endmodule

// File: tb/tb_add_checker.sv
// tb/tb_add_checker.sv - directed table-driven bench for add_checker with a mode-selectable adder under test
module tb_add_checker;

  localparam int S = 1;
  localparam int SWEEP = 256 * (S + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  num1, num2, sum_in;
  logic        cout_in;
  logic        busy, done, pass;
  logic [8:0]  err_count;
  logic [12:0] first_err;
  int          mode = 0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  add_checker #(.SETTLE(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num1      (num1),
    .num2      (num2),
    .sum_in    (sum_in),
    .cout_in   (cout_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .first_err (first_err)
  );

  // adder under test: 0 correct, 1 carry-in stuck at 1, 2 returns 0 only for 0+1
  always_comb begin
    logic [4:0] r;
    r = {1'b0, num1} + {1'b0, num2};
    if (mode == 1) r = r + 5'd1;
    if (mode == 2 && num1 == 4'd0 && num2 == 4'd1) r = 5'd0;
    {cout_in, sum_in} = r;
  end

  typedef struct {
    int mode;
    int exp_err;
    int exp_pass;
    int exp_first;
  } vec_t;

  vec_t tbl[3];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // pulse start, then follow the sweep checking operands cycle by cycle
  task automatic run_sweep(input int repulse_at, input int stop_at,
                           output int cycles, output int bad);
    int c;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    c   = 0;
    bad = 0;
    while (!done && c < 2000) begin
      if (c == stop_at) break;
      if ({num1, num2} != 8'(c / (S + 1)) || !busy) bad++;
      if (c == 0 && (err_count != 9'd0 || first_err != 13'd0)) bad++;
      if (c == repulse_at) start = 1'b1;
      tick(1);
      start = 1'b0;
      c++;
    end
    cycles = c;
  endtask

  initial begin
    int cyc, bad;
    int f1, f2;
`ifdef ADD_CHECKER_FIRST_ERR_EN
    f1 = 13'h0001;
    f2 = 13'h0020;
`else
    f1 = 0;
    f2 = 0;
`endif
    tbl[0] = '{mode: 0, exp_err: 0,   exp_pass: 1, exp_first: 0};
    tbl[1] = '{mode: 1, exp_err: 256, exp_pass: 0, exp_first: f1};
    tbl[2] = '{mode: 2, exp_err: 1,   exp_pass: 0, exp_first: f2};

    // reset state
    #12;
    chk("rst_outs", {busy, done, pass, err_count, first_err, num1, num2}, 0);
    rst_n = 1'b1;
    tick(3);
    chk("idle_busy", busy, 0);

    foreach (tbl[i]) begin
      mode = tbl[i].mode;
      run_sweep(-1, -1, cyc, bad);
      chk($sformatf("v%0d_cycles", i), cyc, SWEEP);
      chk($sformatf("v%0d_seq", i), bad, 0);
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_pass", i), pass, tbl[i].exp_pass);
      chk($sformatf("v%0d_err", i), err_count, tbl[i].exp_err);
      chk($sformatf("v%0d_first", i), first_err, tbl[i].exp_first);
      tick(5);
      chk($sformatf("v%0d_done_held", i), {done, busy, err_count}, {1'b1, 1'b0, 9'(tbl[i].exp_err)});
    end

    // reset in the middle of a sweep at idx 100
    mode = 1;
    run_sweep(-1, 200, cyc, bad);
    chk("mid_seq", bad, 0);
    chk("mid_err", err_count, 100);
    chk("mid_idx", {num1, num2}, 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {busy, done, pass, err_count, first_err, num1, num2}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("post_rst_idle", {busy, done}, 0);
    mode = 0;
    run_sweep(-1, -1, cyc, bad);
    chk("post_rst_cycles", cyc, SWEEP);
    chk("post_rst_seq", bad, 0);
    chk("post_rst_pass", {done, pass, err_count}, {2'b11, 9'd0});

    // start re-pulsed while busy has no effect
    mode = 2;
    run_sweep(51, -1, cyc, bad);
    chk("repulse_cycles", cyc, SWEEP);
    chk("repulse_seq", bad, 0);
    chk("repulse_err", err_count, 1);
    chk("repulse_first", first_err, f2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
